// File: rtl/control_sequencer.sv
// control_sequencer: hardwired T-state control unit for the DataPath.
// Runs fetch (T0-T2) then a class-specific execute (T3-T7) decoded from the opcode field of ir.
// Memory phases (T1, ld T6, st T7) wait on mem_ready with a bounded wait; a timeout sets the
// sticky mem_err flag and parks the sequencer in HALTED.
// Ports:
//   clock, clear             rising-edge clock, asynchronous active-high reset
//   run                      leave IDLE / continue with the next instruction after a retire
//   ir                       current IR contents; opcode = ir[IR_W-1 -: OPCODE_W]
//   mem_ready                memory completes the current Read/Write this cycle
//   PCout..BAout             bus-drive strobes (at most one active)
//   MARin..Rin               register-load strobes
//   IncPC,Read,Write,Gr*     control strobes
//   alu_op                   ALU operation while ZLowIn=1, else 0
//   state                    IDLE=0, T0..T7=7..14, HALTED=15
//   instr_done, illegal      single-cycle pulses
//   mem_err                  sticky memory-timeout flag
//   instr_count              retired instruction count, wraps
module control_sequencer #(
    parameter int unsigned IR_W         = 32,
    parameter int unsigned OPCODE_W     = 5,
    parameter int unsigned MEM_WAIT_MAX = 15,
    parameter int unsigned COUNT_W      = 16
) (
    input  logic                clock,
    input  logic                clear,
    input  logic                run,
    input  logic [IR_W-1:0]     ir,
    input  logic                mem_ready,
    output logic                PCout,
    output logic                Zlowout,
    output logic                MDRout,
    output logic                Rout,
    output logic                Cout,
    output logic                BAout,
    output logic                MARin,
    output logic                PCin,
    output logic                MDRin,
    output logic                IRin,
    output logic                Yin,
    output logic                ZLowIn,
    output logic                Rin,
    output logic                IncPC,
    output logic                Read,
    output logic                Write,
    output logic                Gra,
    output logic                Grb,
    output logic                Grc,
    output logic [OPCODE_W-1:0] alu_op,
    output logic [3:0]          state,
    output logic                instr_done,
    output logic                illegal,
    output logic                mem_err,
    output logic [COUNT_W-1:0]  instr_count
);

    localparam int unsigned WAIT_W = (MEM_WAIT_MAX > 1) ? $clog2(MEM_WAIT_MAX) : 1;

    localparam logic [OPCODE_W-1:0] OP_LD    = OPCODE_W'(0);
    localparam logic [OPCODE_W-1:0] OP_LDI   = OPCODE_W'(1);
    localparam logic [OPCODE_W-1:0] OP_ST    = OPCODE_W'(2);
    localparam logic [OPCODE_W-1:0] OP_ADD   = OPCODE_W'(3);
    localparam logic [OPCODE_W-1:0] OP_AND   = OPCODE_W'(5);
    localparam logic [OPCODE_W-1:0] OP_OR    = OPCODE_W'(6);
    localparam logic [OPCODE_W-1:0] OP_ALU_R_LAST = OPCODE_W'(11);
    localparam logic [OPCODE_W-1:0] OP_ADDI  = OPCODE_W'(12);
    localparam logic [OPCODE_W-1:0] OP_ANDI  = OPCODE_W'(13);
    localparam logic [OPCODE_W-1:0] OP_ORI   = OPCODE_W'(14);
    localparam logic [OPCODE_W-1:0] OP_NOP   = OPCODE_W'(26);
    localparam logic [OPCODE_W-1:0] OP_HALT  = OPCODE_W'(27);

    typedef enum logic [3:0] {
        StIdle   = 4'd0,
        StT0     = 4'd7,
        StT1     = 4'd8,
        StT2     = 4'd9,
        StT3     = 4'd10,
        StT4     = 4'd11,
        StT5     = 4'd12,
        StT6     = 4'd13,
        StT7     = 4'd14,
        StHalted = 4'd15
    } state_t;

    typedef enum logic [2:0] {
        ClsLd, ClsLdi, ClsSt, ClsAluR, ClsAluI, ClsNop, ClsHalt, ClsIllegal
    } cls_t;

    state_t              state_q, state_d;
    logic [WAIT_W-1:0]   wait_cnt_q, wait_cnt_d;
    logic                mem_err_q, mem_err_d;
    logic [COUNT_W-1:0]  instr_count_q, instr_count_d;

    logic [OPCODE_W-1:0] opcode;
    logic [OPCODE_W-1:0] imm_op;
    cls_t                cls;
    logic                in_wait;
    logic                wait_last;
    logic                fault;
    logic                retire;
    logic                unused_ir;

    assign opcode    = ir[IR_W-1 -: OPCODE_W];
    assign unused_ir = ^ir[IR_W-OPCODE_W-1:0];
    assign wait_last = (wait_cnt_q == WAIT_W'(MEM_WAIT_MAX - 1));

    // Instruction class and immediate-form ALU operation.
    always_comb begin
        cls    = ClsIllegal;
        imm_op = '0;
        if (opcode == OP_LD) begin
            cls = ClsLd;
        end else if (opcode == OP_LDI) begin
            cls = ClsLdi;
        end else if (opcode == OP_ST) begin
            cls = ClsSt;
        end else if (opcode >= OP_ADD && opcode <= OP_ALU_R_LAST) begin
            cls = ClsAluR;
        end else if (opcode == OP_ADDI) begin
            cls    = ClsAluI;
            imm_op = OP_ADD;
        end else if (opcode == OP_ANDI) begin
            cls    = ClsAluI;
            imm_op = OP_AND;
        end else if (opcode == OP_ORI) begin
            cls    = ClsAluI;
            imm_op = OP_OR;
        end else if (opcode == OP_NOP) begin
            cls = ClsNop;
        end else if (opcode == OP_HALT) begin
            cls = ClsHalt;
        end
    end

    // Next state and strobe decode.
    always_comb begin
        {PCout, Zlowout, MDRout, Rout, Cout, BAout} = '0;
        {MARin, PCin, MDRin, IRin, Yin, ZLowIn, Rin} = '0;
        {IncPC, Read, Write, Gra, Grb, Grc} = '0;
        alu_op     = '0;
        instr_done = 1'b0;
        illegal    = 1'b0;
        state_d    = state_q;
        in_wait    = 1'b0;
        fault      = 1'b0;
        retire     = 1'b0;

        case (state_q)
            StIdle: begin
                if (run) state_d = StT0;
            end
            StT0: begin
                PCout   = 1'b1;
                MARin   = 1'b1;
                IncPC   = 1'b1;
                ZLowIn  = 1'b1;
                state_d = StT1;
            end
            StT1: begin
                Zlowout = 1'b1;
                PCin    = 1'b1;
                Read    = 1'b1;
                MDRin   = 1'b1;
                in_wait = 1'b1;
                if (mem_ready)      state_d = StT2;
                else if (wait_last) fault = 1'b1;
            end
            StT2: begin
                MDRout  = 1'b1;
                IRin    = 1'b1;
                state_d = StT3;
            end
            StT3: begin
                case (cls)
                    ClsLd, ClsLdi, ClsSt: begin
                        Grb     = 1'b1;
                        BAout   = 1'b1;
                        Yin     = 1'b1;
                        state_d = StT4;
                    end
                    ClsAluR, ClsAluI: begin
                        Grb     = 1'b1;
                        Rout    = 1'b1;
                        Yin     = 1'b1;
                        state_d = StT4;
                    end
                    ClsNop: begin
                        instr_done = 1'b1;
                        retire     = 1'b1;
                    end
                    ClsHalt: begin
                        instr_done = 1'b1;
                        state_d    = StHalted;
                    end
                    default: begin
                        illegal = 1'b1;
                        retire  = 1'b1;
                    end
                endcase
            end
            StT4: begin
                ZLowIn  = 1'b1;
                state_d = StT5;
                case (cls)
                    ClsAluR: begin
                        Grc    = 1'b1;
                        Rout   = 1'b1;
                        alu_op = opcode;
                    end
                    ClsAluI: begin
                        Cout   = 1'b1;
                        alu_op = imm_op;
                    end
                    default: begin
                        // ld/ldi/st: effective address = base + offset
                        Cout   = 1'b1;
                        alu_op = OP_ADD;
                    end
                endcase
            end
            StT5: begin
                Zlowout = 1'b1;
                if (cls == ClsLd || cls == ClsSt) begin
                    MARin   = 1'b1;
                    state_d = StT6;
                end else begin
                    Gra        = 1'b1;
                    Rin        = 1'b1;
                    instr_done = 1'b1;
                    retire     = 1'b1;
                end
            end
            StT6: begin
                if (cls == ClsSt) begin
                    Gra     = 1'b1;
                    Rout    = 1'b1;
                    MDRin   = 1'b1;
                    state_d = StT7;
                end else begin
                    Read    = 1'b1;
                    MDRin   = 1'b1;
                    in_wait = 1'b1;
                    if (mem_ready)      state_d = StT7;
                    else if (wait_last) fault = 1'b1;
                end
            end
            StT7: begin
                if (cls == ClsSt) begin
                    Write   = 1'b1;
                    in_wait = 1'b1;
                    if (mem_ready) begin
                        instr_done = 1'b1;
                        retire     = 1'b1;
                    end else if (wait_last) begin
                        fault = 1'b1;
                    end
                end else begin
                    MDRout     = 1'b1;
                    Gra        = 1'b1;
                    Rin        = 1'b1;
                    instr_done = 1'b1;
                    retire     = 1'b1;
                end
            end
            StHalted: begin
                state_d = StHalted;
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        if (fault)  state_d = StHalted;
        if (retire) state_d = run ? StT0 : StIdle;
    end

    // Wait counter runs only while a wait state is held; any transition restarts it at 0.
    always_comb begin
        wait_cnt_d    = (in_wait && !mem_ready && !fault) ? wait_cnt_q + WAIT_W'(1) : '0;
        mem_err_d     = mem_err_q | fault;
        instr_count_d = instr_done ? instr_count_q + COUNT_W'(1) : instr_count_q;
    end

    always_ff @(posedge clock or posedge clear) begin
        if (clear) begin
            state_q       <= StIdle;
            wait_cnt_q    <= '0;
            mem_err_q     <= 1'b0;
            instr_count_q <= '0;
        end else begin
            state_q       <= state_d;
            wait_cnt_q    <= wait_cnt_d;
            mem_err_q     <= mem_err_d;
            instr_count_q <= instr_count_d;
        end
    end

    assign state       = state_q;
    assign mem_err     = mem_err_q;
    assign instr_count = instr_count_q;

endmodule
